// File: rtl/cpu_pkg.sv
// Shared encodings, constants and payload types for the execute stage and its multiplier.
package cpu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned CNT_W  = 5;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_RTYPE = 2'b10;
    localparam logic [1:0] ALU_OR    = 2'b11;

    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_SLT  = 6'h2A;
    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_MFHI = 6'h10;
    localparam logic [5:0] FUNCT_MFLO = 6'h12;
    localparam logic [5:0] FUNCT_MULT = 6'h18;

    typedef enum logic {IDLE, MUL} mul_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] write_data;
        logic [REG_W-1:0]  write_reg;
        logic              mem_read;
        logic              mem_write;
        logic              mem_to_reg;
        logic              reg_write;
    } exmem_t;

    function automatic logic [DATA_W-1:0] abs32(input logic [DATA_W-1:0] x);
        return x[DATA_W-1] ? DATA_W'(-x) : x;
    endfunction

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, bundled for port connection.
interface ex_stage_if;
    import cpu_pkg::*;

    logic [DATA_W-1:0] pcAdd4EX;
    logic [DATA_W-1:0] readData1EX;
    logic [DATA_W-1:0] readData2EX;
    logic [DATA_W-1:0] signExtendEX;
    logic [REG_W-1:0]  rtEX;
    logic [REG_W-1:0]  rdEX;
    logic              regDstEX;
    logic              branchEqEX;
    logic              branchNeEX;
    logic              memReadEX;
    logic              memtoRegEX;
    logic              memWriteEX;
    logic              aluSrcEX;
    logic              regWriteEX;
    logic [1:0]        aluOpEX;

    logic              pcSrc;
    logic [DATA_W-1:0] branchTarget;
    logic              busyEX;
    logic [DATA_W-1:0] aluResultMEM;
    logic [DATA_W-1:0] writeDataMEM;
    logic [REG_W-1:0]  writeRegMEM;
    logic              memReadMEM;
    logic              memWriteMEM;
    logic              memtoRegMEM;
    logic              regWriteMEM;

    modport slave (
        input  pcAdd4EX, readData1EX, readData2EX, signExtendEX, rtEX, rdEX,
               regDstEX, branchEqEX, branchNeEX, memReadEX, memtoRegEX,
               memWriteEX, aluSrcEX, regWriteEX, aluOpEX,
        output pcSrc, branchTarget, busyEX, aluResultMEM, writeDataMEM,
               writeRegMEM, memReadMEM, memWriteMEM, memtoRegMEM, regWriteMEM
    );

    modport master (
        output pcAdd4EX, readData1EX, readData2EX, signExtendEX, rtEX, rdEX,
               regDstEX, branchEqEX, branchNeEX, memReadEX, memtoRegEX,
               memWriteEX, aluSrcEX, regWriteEX, aluOpEX,
        input  pcSrc, branchTarget, busyEX, aluResultMEM, writeDataMEM,
               writeRegMEM, memReadMEM, memWriteMEM, memtoRegMEM, regWriteMEM
    );

endinterface

// File: rtl/mult_seq.sv
// 32-step shift-add signed multiplier on magnitudes; result lands in HI/LO on the final step.
module mult_seq
    import cpu_pkg::*;
(
    input  logic              clock,
    input  logic              resetN,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    mul_state_e        state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PROD_W-1:0] acc_q, acc_d;
    logic [PROD_W-1:0] mcand_q, mcand_d;
    logic [DATA_W-1:0] mplier_q, mplier_d;
    logic              sign_q, sign_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [PROD_W-1:0] sum;
    logic [PROD_W-1:0] prod;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q  <= IDLE;
            count_q  <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            sign_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            sign_q   <= sign_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        sign_d   = sign_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        sum      = acc_q + (mplier_q[0] ? mcand_q : '0);
        prod     = sign_q ? PROD_W'(-sum) : sum;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = MUL;
                    count_d  = '0;
                    acc_d    = '0;
                    mcand_d  = {{DATA_W{1'b0}}, abs32(a)};
                    mplier_d = abs32(b);
                    sign_d   = a[DATA_W-1] ^ b[DATA_W-1];
                end
            end
            MUL: begin
                acc_d    = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CNT_W'(1);
                // Last step: commit the signed product instead of waiting a cycle.
                if (count_q == CNT_W'(31)) begin
                    state_d = IDLE;
                    hi_d    = prod[PROD_W-1:DATA_W];
                    lo_d    = prod[DATA_W-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == MUL);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU, branch resolution, multiply stall and the EX/MEM pipeline register.
module ex_stage
    import cpu_pkg::*;
(
    input  logic     clock,
    input  logic     resetN,
    ex_stage_if.slave bus
);

    logic [DATA_W-1:0] op_a, op_b, diff, alu_result;
    logic [5:0]        funct;
    logic [4:0]        shamt;
    logic              zero, is_mult, busy;
    logic [DATA_W-1:0] hi, lo;
    exmem_t            exmem_q, exmem_d;

    assign op_a    = bus.readData1EX;
    assign op_b    = bus.aluSrcEX ? bus.signExtendEX : bus.readData2EX;
    assign funct   = bus.signExtendEX[5:0];
    assign shamt   = bus.signExtendEX[10:6];
    assign diff    = op_a - op_b;
    assign zero    = (diff == '0);
    assign is_mult = (bus.aluOpEX == ALU_RTYPE) && (funct == FUNCT_MULT);

    mult_seq u_mult (
        .clock  (clock),
        .resetN (resetN),
        .start  (is_mult),
        .a      (op_a),
        .b      (op_b),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always_comb begin
        alu_result = '0;
        case (bus.aluOpEX)
            ALU_ADD: alu_result = op_a + op_b;
            ALU_SUB: alu_result = diff;
            ALU_OR:  alu_result = op_a | op_b;
            default: begin
                case (funct)
                    FUNCT_ADD:  alu_result = op_a + op_b;
                    FUNCT_SUB:  alu_result = diff;
                    FUNCT_AND:  alu_result = op_a & op_b;
                    FUNCT_OR:   alu_result = op_a | op_b;
                    FUNCT_SLT:  alu_result = DATA_W'($signed(op_a) < $signed(op_b));
                    FUNCT_SLL:  alu_result = op_b << shamt;
                    FUNCT_MFHI: alu_result = hi;
                    FUNCT_MFLO: alu_result = lo;
                    default:    alu_result = '0;
                endcase
            end
        endcase
    end

    // A mult and every cycle spent multiplying push a bubble into MEM.
    always_comb begin
        exmem_d = '0;
        if (!busy && !is_mult) begin
            exmem_d.alu_result = alu_result;
            exmem_d.write_data = bus.readData2EX;
            exmem_d.write_reg  = bus.regDstEX ? bus.rdEX : bus.rtEX;
            exmem_d.mem_read   = bus.memReadEX;
            exmem_d.mem_write  = bus.memWriteEX;
            exmem_d.mem_to_reg = bus.memtoRegEX;
            exmem_d.reg_write  = bus.regWriteEX;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) exmem_q <= '0;
        else         exmem_q <= exmem_d;
    end

    assign bus.pcSrc        = ~busy & ((bus.branchEqEX & zero) | (bus.branchNeEX & ~zero));
    assign bus.branchTarget = bus.pcAdd4EX + {bus.signExtendEX[DATA_W-3:0], 2'b00};
    assign bus.busyEX       = busy;
    assign bus.aluResultMEM = exmem_q.alu_result;
    assign bus.writeDataMEM = exmem_q.write_data;
    assign bus.writeRegMEM  = exmem_q.write_reg;
    assign bus.memReadMEM   = exmem_q.mem_read;
    assign bus.memWriteMEM  = exmem_q.mem_write;
    assign bus.memtoRegMEM  = exmem_q.mem_to_reg;
    assign bus.regWriteMEM  = exmem_q.reg_write;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: reset, ALU sweep, branches, multiply timing and abort.
module tb_ex_stage;

    logic clk;
    logic rst_n;
    int   checks;
    int   passed;

    ex_stage_if bus ();

    ex_stage dut (
        .clock  (clk),
        .resetN (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.pcAdd4EX     = '0;
        bus.readData1EX  = '0;
        bus.readData2EX  = '0;
        bus.signExtendEX = '0;
        bus.rtEX         = '0;
        bus.rdEX         = '0;
        bus.regDstEX     = 1'b0;
        bus.branchEqEX   = 1'b0;
        bus.branchNeEX   = 1'b0;
        bus.memReadEX    = 1'b0;
        bus.memtoRegEX   = 1'b0;
        bus.memWriteEX   = 1'b0;
        bus.aluSrcEX     = 1'b0;
        bus.regWriteEX   = 1'b0;
        bus.aluOpEX      = 2'b00;
    endtask

    task automatic drive_r(input logic [31:0] a, input logic [31:0] b,
                           input logic [5:0] funct, input logic [4:0] shamt,
                           input logic [4:0] rd);
        clear_inputs();
        bus.aluOpEX      = 2'b10;
        bus.regDstEX     = 1'b1;
        bus.regWriteEX   = 1'b1;
        bus.readData1EX  = a;
        bus.readData2EX  = b;
        bus.rdEX         = rd;
        bus.signExtendEX = {21'd0, shamt, funct};
    endtask

    // Follows a mult driven this cycle: loads the follower, counts busy cycles, notes non-bubbles.
    task automatic mult_span(input logic [31:0] fa, input logic [31:0] fb,
                             input logic [5:0] ff, input logic [4:0] frd,
                             output int cycles, output bit bubbles_ok);
        cycles     = 0;
        bubbles_ok = 1'b1;
        step();
        drive_r(fa, fb, ff, 5'd0, frd);
        if (bus.aluResultMEM !== 32'd0 || bus.regWriteMEM !== 1'b0) bubbles_ok = 1'b0;
        while (bus.busyEX === 1'b1 && cycles < 40) begin
            cycles++;
            step();
            if (bus.aluResultMEM !== 32'd0 || bus.regWriteMEM !== 1'b0 ||
                bus.writeRegMEM !== 5'd0 || bus.memWriteMEM !== 1'b0) bubbles_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (bus.aluResultMEM !== 32'd0 || bus.regWriteMEM !== 1'b0 || bus.busyEX !== 1'b0 ||
            bus.pcSrc !== 1'b0)
            $display("FAIL reset_por: res=%h rw=%b busy=%b pcSrc=%b, want 0", bus.aluResultMEM,
                     bus.regWriteMEM, bus.busyEX, bus.pcSrc);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        // an add lands in MEM, then reset is pulled asynchronously mid-cycle
        drive_r(32'd1, 32'd2, 6'h20, 5'd0, 5'd9);
        bus.memWriteEX = 1'b1;
        step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.aluResultMEM !== 32'd0 || bus.writeRegMEM !== 5'd0 || bus.regWriteMEM !== 1'b0 ||
            bus.memWriteMEM !== 1'b0 || bus.busyEX !== 1'b0)
            $display("FAIL reset_mid: res=%h wr=%0d rw=%b mw=%b busy=%b, want all 0",
                     bus.aluResultMEM, bus.writeRegMEM, bus.regWriteMEM, bus.memWriteMEM, bus.busyEX);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        clear_inputs();
        bus.readData1EX  = 32'd5;
        bus.signExtendEX = 32'd7;
        bus.aluSrcEX     = 1'b1;
        bus.regWriteEX   = 1'b1;
        bus.rtEX         = 5'd3;
        step();
        checks++;
        if (bus.aluResultMEM !== 32'd12 || bus.writeRegMEM !== 5'd3 || bus.regWriteMEM !== 1'b1)
            $display("FAIL addi_after_reset: res=%h wr=%0d rw=%b, want 0000000c 3 1",
                     bus.aluResultMEM, bus.writeRegMEM, bus.regWriteMEM);
        else passed++;
    endtask

    task automatic test_rtype();
        logic [5:0]  fn  [7];
        logic [4:0]  sh  [7];
        logic [31:0] exp [7];
        fn[0] = 6'h20; sh[0] = 5'd0; exp[0] = 32'h0000_0000;
        fn[1] = 6'h2A; sh[1] = 5'd0; exp[1] = 32'h0000_0001;
        fn[2] = 6'h00; sh[2] = 5'd4; exp[2] = 32'h0000_0010;
        fn[3] = 6'h3F; sh[3] = 5'd0; exp[3] = 32'h0000_0000;
        fn[4] = 6'h22; sh[4] = 5'd0; exp[4] = 32'hFFFF_FFFE;
        fn[5] = 6'h24; sh[5] = 5'd0; exp[5] = 32'h0000_0001;
        fn[6] = 6'h25; sh[6] = 5'd0; exp[6] = 32'hFFFF_FFFF;
        for (int i = 0; i < 7; i++) begin
            drive_r(32'hFFFF_FFFF, 32'd1, fn[i], sh[i], 5'(10 + i));
            step();
            checks++;
            if (bus.aluResultMEM !== exp[i] || bus.writeRegMEM !== 5'(10 + i) ||
                bus.writeDataMEM !== 32'd1)
                $display("FAIL rtype_funct_%h: res=%h wr=%0d wd=%h, want %h %0d 00000001",
                         fn[i], bus.aluResultMEM, bus.writeRegMEM, bus.writeDataMEM, exp[i], 10 + i);
            else passed++;
        end
    endtask

    task automatic test_branch();
        clear_inputs();
        bus.pcAdd4EX     = 32'h0000_0100;
        bus.signExtendEX = 32'hFFFF_FFFE;
        bus.readData1EX  = 32'd9;
        bus.readData2EX  = 32'd9;
        bus.aluOpEX      = 2'b01;
        bus.branchEqEX   = 1'b1;
        #1;
        checks++;
        if (bus.pcSrc !== 1'b1 || bus.branchTarget !== 32'h0000_00F8)
            $display("FAIL beq_taken: pcSrc=%b tgt=%h, want 1 000000f8", bus.pcSrc, bus.branchTarget);
        else passed++;
        bus.branchEqEX = 1'b0;
        bus.branchNeEX = 1'b1;
        #1;
        checks++;
        if (bus.pcSrc !== 1'b0)
            $display("FAIL bne_equal: pcSrc=%b, want 0", bus.pcSrc);
        else passed++;
        bus.readData2EX = 32'd8;
        #1;
        checks++;
        if (bus.pcSrc !== 1'b1)
            $display("FAIL bne_unequal: pcSrc=%b, want 1", bus.pcSrc);
        else passed++;
        step();
    endtask

    task automatic test_mult();
        int cycles;
        bit ok;
        drive_r(32'hFFFF_FFFD, 32'd7, 6'h18, 5'd0, 5'd5);
        #1;
        checks++;
        if (bus.busyEX !== 1'b0)
            $display("FAIL mult_busy_issue: busy=%b, want 0", bus.busyEX);
        else passed++;
        step();
        drive_r(32'd0, 32'd0, 6'h10, 5'd0, 5'd8);
        bus.branchEqEX = 1'b1;
        #1;
        checks++;
        if (bus.pcSrc !== 1'b0 || bus.busyEX !== 1'b1)
            $display("FAIL branch_while_busy: pcSrc=%b busy=%b, want 0 1", bus.pcSrc, bus.busyEX);
        else passed++;
        bus.branchEqEX = 1'b0;
        cycles = 1;
        ok = 1'b1;
        if (bus.aluResultMEM !== 32'd0 || bus.regWriteMEM !== 1'b0) ok = 1'b0;
        while (bus.busyEX === 1'b1 && cycles < 40) begin
            step();
            if (bus.aluResultMEM !== 32'd0 || bus.regWriteMEM !== 1'b0) ok = 1'b0;
            if (bus.busyEX === 1'b1) cycles++;
        end
        checks++;
        if (cycles !== 32 || !ok)
            $display("FAIL mult_busy_span: busy_cycles=%0d bubbles_ok=%0b, want 32 1", cycles, ok);
        else passed++;
        step();
        checks++;
        if (bus.aluResultMEM !== 32'hFFFF_FFFF || bus.writeRegMEM !== 5'd8)
            $display("FAIL mfhi_neg21: res=%h wr=%0d, want ffffffff 8", bus.aluResultMEM, bus.writeRegMEM);
        else passed++;
        drive_r(32'd0, 32'd0, 6'h12, 5'd0, 5'd9);
        step();
        checks++;
        if (bus.aluResultMEM !== 32'hFFFF_FFEB)
            $display("FAIL mflo_neg21: res=%h, want ffffffeb", bus.aluResultMEM);
        else passed++;
    endtask

    task automatic test_big();
        int cycles;
        bit ok;
        drive_r(32'h7FFF_FFFF, 32'h7FFF_FFFF, 6'h18, 5'd0, 5'd0);
        mult_span(32'd0, 32'd0, 6'h10, 5'd4, cycles, ok);
        step();
        checks++;
        if (cycles !== 32 || bus.aluResultMEM !== 32'h3FFF_FFFF)
            $display("FAIL mfhi_big: cycles=%0d hi=%h, want 32 3fffffff", cycles, bus.aluResultMEM);
        else passed++;
        drive_r(32'd0, 32'd0, 6'h12, 5'd0, 5'd4);
        step();
        checks++;
        if (bus.aluResultMEM !== 32'h0000_0001)
            $display("FAIL mflo_big: lo=%h, want 00000001", bus.aluResultMEM);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int c1, c2;
        bit ok1, ok2;
        drive_r(32'd2, 32'd3, 6'h18, 5'd0, 5'd0);
        mult_span(32'hFFFF_FFFC, 32'd5, 6'h18, 5'd0, c1, ok1);
        checks++;
        if (c1 !== 32 || !ok1 || bus.busyEX !== 1'b0)
            $display("FAIL b2b_first: cycles=%0d ok=%0b busy=%b, want 32 1 0", c1, ok1, bus.busyEX);
        else passed++;
        mult_span(32'd0, 32'd0, 6'h12, 5'd6, c2, ok2);
        checks++;
        if (c2 !== 32 || !ok2)
            $display("FAIL b2b_second: cycles=%0d ok=%0b, want 32 1", c2, ok2);
        else passed++;
        step();
        checks++;
        if (bus.aluResultMEM !== 32'hFFFF_FFEC || bus.writeRegMEM !== 5'd6)
            $display("FAIL b2b_mflo: res=%h wr=%0d, want ffffffec 6", bus.aluResultMEM, bus.writeRegMEM);
        else passed++;
    endtask

    task automatic test_abort();
        drive_r(32'hFFFF_FFFD, 32'd7, 6'h18, 5'd0, 5'd0);
        step();
        drive_r(32'd0, 32'd0, 6'h10, 5'd0, 5'd7);
        repeat (9) step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.busyEX !== 1'b0 || bus.aluResultMEM !== 32'd0)
            $display("FAIL abort_busy: busy=%b res=%h, want 0 0", bus.busyEX, bus.aluResultMEM);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checks++;
        if (bus.aluResultMEM !== 32'd0 || bus.writeRegMEM !== 5'd7 || bus.regWriteMEM !== 1'b1)
            $display("FAIL abort_hi: res=%h wr=%0d rw=%b, want 0 7 1", bus.aluResultMEM,
                     bus.writeRegMEM, bus.regWriteMEM);
        else passed++;
        drive_r(32'd0, 32'd0, 6'h12, 5'd0, 5'd7);
        step();
        checks++;
        if (bus.aluResultMEM !== 32'd0 || bus.regWriteMEM !== 1'b1)
            $display("FAIL abort_lo: res=%h rw=%b, want 0 1", bus.aluResultMEM, bus.regWriteMEM);
        else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        rst_n  = 1'b0;
        clear_inputs();
        test_reset();
        test_rtype();
        test_branch();
        test_mult();
        test_big();
        test_back_to_back();
        test_abort();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage pipelined MIPS core. It consumes the ID/EX pipeline register outputs, decodes the ALU operation and executes it, and resolves beq/bne. It runs a 32-cycle iterative signed multiplier that writes the HI/LO registers, and owns the EX/MEM pipeline register feeding the MEM stage. While a multiply is in flight it stalls the front of the pipeline.

## Interface
Parameters:
- none. Widths are fixed at 32-bit data and 5-bit register index.

Ports:
- `clock`  in  1  rising-edge clock for the whole block.
- `resetN`  in  1  asynchronous, active-low reset.
- `pcAdd4EX`, `readData1EX`, `readData2EX`, `signExtendEX`  in  32 each  from ID/EX; `signExtendEX[5:0]` = funct, `[10:6]` = shamt.
- `rtEX`, `rdEX`  in  5 each  destination candidates.
- `regDstEX`, `branchEqEX`, `branchNeEX`, `memReadEX`, `memtoRegEX`, `memWriteEX`, `aluSrcEX`, `regWriteEX`  in  1 each  control bits.
- `aluOpEX`  in  2  00 add, 01 sub, 10 R-type (funct), 11 or.
- `pcSrc`  out  1  branch taken (combinational).
- `branchTarget`  out  32  `pcAdd4EX + (signExtendEX << 2)`, mod 2^32.
- `busyEX`  out  1  multiplier active; IF/ID and ID/EX must hold.
- `aluResultMEM`, `writeDataMEM`  out  32 each  registered.
- `writeRegMEM`  out  5  registered.
- `memReadMEM`, `memWriteMEM`, `memtoRegMEM`, `regWriteMEM`  out  1 each  registered.

## Operation
- Operand B = `aluSrcEX ? signExtendEX : readData2EX`. Destination register = `regDstEX ? rdEX : rtEX`.
- R-type funct codes:
  - 0x20 add; 0x22 sub; 0x24 and; 0x25 or.
  - 0x2A slt: signed, result 1 or 0.
  - 0x00 sll: shifts B by shamt.
  - 0x10 mfhi → HI; 0x12 mflo → LO.
  - 0x18 mult → start multiply.
  - Any other funct → result 0.
- Arithmetic wraps mod 2^32; no overflow trap.
- zero = (A − B == 0), computed regardless of aluOp. `pcSrc = (branchEqEX & zero) | (branchNeEX & ~zero)`; forced 0 while `busyEX`.
- Multiplier FSM states:
  - IDLE → MUL when R-type funct 0x18 is in EX. On that edge it latches |A| and |B|, sign = A[31]^B[31], and count = 0.
  - MUL: one shift-add step per cycle, count increments each step.
  - MUL → IDLE on the edge where count == 31. On that edge {HI,LO} receives the 64-bit product, two's-complement negated if sign = 1.
- A mult writes no GPR; its EX/MEM entry is a bubble.
- `busyEX = (state == MUL)`. While busy:
  - EX/MEM loads a bubble (all four control bits 0, data 0).
  - Upstream holds the instruction that follows the mult.
- mfhi/mflo read HI/LO as they stand when the instruction is in EX with `busyEX` = 0, so they see the completed product.
- EX/MEM otherwise loads the ALU result, `readData2EX`, the destination register and the control bits every edge.

## Timing
- Reset (asynchronous, whenever `resetN` = 0):
  - All EX/MEM outputs 0, HI = LO = 0, state IDLE, count 0.
  - `busyEX` and `pcSrc` read 0.
- Reset asserted mid-multiply aborts the multiply; HI/LO are 0 afterwards.
- Latency:
  - ALU result reaches `aluResultMEM` 1 cycle after the instruction enters EX.
  - `pcSrc` and `branchTarget` are valid in the same cycle.
- Multiply timing:
  - mult in EX at cycle t; `busyEX` is high for cycles t+1 … t+32.
  - HI/LO are valid from cycle t+33.
  - The next instruction executes in cycle t+33.
- A mult immediately followed by mult: the second starts at t+33, with no overlap.
- A branch never coexists with busy. Branch input bits seen while busy are ignored.

## Structure
- Shared package `cpu_pkg` holds:
  - aluOp encodings;
  - funct constants (ADD, SUB, AND, OR, SLT, SLL, MULT, MFHI, MFLO);
  - multiplier state enum {IDLE, MUL}.
- Sub-module `mult_seq` contains the FSM, the 5-bit counter, the 64-bit accumulator, sign handling and HI/LO.
  - Ports: start, a, b, busy, hi, lo, plus `clock`/`resetN`.
- `ex_stage` keeps the ALU, branch logic and EX/MEM register.

## Test plan
- Reset: drive `resetN` = 0 mid-run → all MEM outputs 0, `busyEX` = 0; after release, add 5+7 → `aluResultMEM` = 12 next cycle.
- R-type sweep: A=0xFFFFFFFF, B=1:
  - add → 0x00000000
  - slt → 1
  - sll shamt 4 on B=1 → 0x10
  - funct 0x3F → 0
- Branch, pcAdd4=0x100, imm=0xFFFE:
  - beq with A==B → `pcSrc` = 1, `branchTarget` = 0xF8 in the same cycle.
  - bne with A==B → `pcSrc` = 0.
- Multiply: mult −3 × 7 → `busyEX` high exactly 32 cycles, EX/MEM bubbles; then mfhi → 0xFFFFFFFF, mflo → 0xFFFFFFEB.
- Large operands: mult 0x7FFFFFFF × 0x7FFFFFFF → HI 0x3FFFFFFF, LO 0x00000001; back-to-back mult restarts only after the first completes.
- Abort: reset at cycle 10 of a multiply → `busyEX` 0 immediately, HI = LO = 0.
